// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter: schedules DDR burst commands for the camera write FIFO and
// the display read FIFO. Round-robin on contention. Tracks ping-pong frame buffers.
//
// state | meaning
// IDLE  | nothing outstanding; waits for init_done and a request
// ARB   | chooses write or read and captures the command address
// CMD   | cmd_en held high until the controller accepts
// WAIT  | burst data phase in flight; waits for burst_done
module ddr_frame_arbiter #(
    parameter int BURST_LEN    = 128,
    parameter int FRAME_WORDS  = 786432,
    parameter int FRAME_STRIDE = 'h0100000,
    parameter int RFIFO_DEPTH  = 1024,
    parameter int CNT_W        = 11,
    parameter int ADDR_W       = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [CNT_W-1:0]  wfifo_level,
    input  logic [CNT_W-1:0]  rfifo_level,
    output logic              cmd_en,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              cmd_rdy,
    input  logic              burst_done,
    output logic              wr_buf,
    output logic              rd_buf,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  WR_LVL   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  RD_LVL   = CNT_W'(RFIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_W  = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BURST_W  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(FRAME_STRIDE);

    typedef enum logic [1:0] {IDLE, ARB, CMD, WAIT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_off, rd_off;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_active, last_wr, wr_pend, rd_pend;
    logic              wr_req, rd_req, grant_wr, accept;
    logic              wr_hold, rd_hold, wr_apply, rd_apply, wr_buf_nx;

    assign cmd_len  = 8'(BURST_LEN - 1);

    // The offset guards keep requests from running past the end of a frame.
    assign wr_req   = wr_active && (wr_off < FRAME_W) && (wfifo_level >= WR_LVL);
    assign rd_req   = (rd_off < FRAME_W) && (rfifo_level <= RD_LVL);
    assign grant_wr = wr_req && (!rd_req || !last_wr);
    assign accept   = (state == CMD) && cmd_rdy;
    assign wr_addr  = (wr_buf ? STRIDE_W : '0) + wr_off;
    assign rd_addr  = (rd_buf ? STRIDE_W : '0) + rd_off;

    // Frame starts wait while their own burst is in flight. Both sides also wait
    // in ARB, so the address being captured cannot change under the grant.
    assign wr_hold  = (state == ARB) ||
                      (cmd_wr && ((state == CMD) || ((state == WAIT) && !burst_done)));
    assign rd_hold  = (state == ARB) ||
                      (!cmd_wr && ((state == CMD) || ((state == WAIT) && !burst_done)));
    assign wr_apply = (wr_frame_start || wr_pend) && !wr_hold;
    assign rd_apply = (rd_frame_start || rd_pend) && !rd_hold;
    // A partial frame keeps its buffer and is overwritten by the next frame.
    assign wr_buf_nx = (wr_apply && (wr_off == FRAME_W)) ? ~wr_buf : wr_buf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and command strobes
    always_comb begin
        state_nx = state;
        cmd_en   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: if (init_done && (wr_req || rd_req)) state_nx = ARB;
            ARB:  state_nx = (init_done && (wr_req || rd_req)) ? CMD : IDLE;
            CMD: begin
                cmd_en = 1'b1;
                if (cmd_rdy) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (burst_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the grant on ARB exit; remember the last accepted direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr   <= 1'b0;
            cmd_addr <= '0;
            last_wr  <= 1'b0;
        end else begin
            if ((state == ARB) && (state_nx == CMD)) begin
                cmd_wr   <= grant_wr;
                cmd_addr <= grant_wr ? wr_addr : rd_addr;
            end
            if (accept) last_wr <= cmd_wr;
        end
    end

    // Write side: frame start handling and offset advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_off    <= '0;
            wr_active <= 1'b0;
            wr_buf    <= 1'b0;
            wr_pend   <= 1'b0;
        end else if (wr_apply) begin
            wr_off    <= '0;
            wr_active <= 1'b1;
            wr_buf    <= wr_buf_nx;
            wr_pend   <= 1'b0;
        end else begin
            if (wr_frame_start) wr_pend <= 1'b1;
            if (accept && cmd_wr) begin
                wr_off <= wr_off + BURST_W;
                if (wr_off + BURST_W == FRAME_W) wr_active <= 1'b0;
            end
        end
    end

    // Read side: always reads the buffer opposite the (possibly just updated) write buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_off  <= '0;
            rd_buf  <= 1'b1;
            rd_pend <= 1'b0;
        end else if (rd_apply) begin
            rd_off  <= '0;
            rd_buf  <= ~wr_buf_nx;
            rd_pend <= 1'b0;
        end else begin
            if (rd_frame_start) rd_pend <= 1'b1;
            if (accept && !cmd_wr) rd_off <= rd_off + BURST_W;
        end
    end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter with a small frame (16 words, 4-word bursts).
module tb_ddr_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, init_done, wr_frame_start, rd_frame_start;
    logic [10:0] wfifo_level, rfifo_level;
    logic        cmd_en, cmd_wr, cmd_rdy, burst_done;
    logic [27:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_buf, rd_buf, busy;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] log_wr[$];
    logic [31:0] log_addr[$];
    int cont_addr[8] = '{0, 32, 4, 36, 8, 40, 12, 44};

    ddr_frame_arbiter #(
        .BURST_LEN(4), .FRAME_WORDS(16), .FRAME_STRIDE(32),
        .RFIFO_DEPTH(1024), .CNT_W(11), .ADDR_W(28)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
        .cmd_en(cmd_en), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_rdy(cmd_rdy), .burst_done(burst_done),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cmds(input int n, input int budget);
        int k;
        k = 0;
        while (log_addr.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("cmd_wait", 32'(log_addr.size()), 32'(n));
    endtask

    task automatic chk_cmd(input string tag, input int idx, input logic [31:0] wr,
                           input logic [31:0] addr);
        logic [31:0] w, a;
        w = 'x;
        a = 'x;
        if (idx < log_addr.size()) begin
            w = log_wr[idx];
            a = log_addr[idx];
        end
        chk($sformatf("%s%0d_wr", tag, idx), w, wr);
        chk($sformatf("%s%0d_addr", tag, idx), a, addr);
    endtask

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_en"}, 32'(cmd_en), 0);
        chk({tag, "_cmd_wr"}, 32'(cmd_wr), 0);
        chk({tag, "_cmd_addr"}, 32'(cmd_addr), 0);
        chk({tag, "_cmd_len"}, 32'(cmd_len), 3);
        chk({tag, "_wr_buf"}, 32'(wr_buf), 0);
        chk({tag, "_rd_buf"}, 32'(rd_buf), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Controller model: logs accepted commands, pulses burst_done 3 cycles after accept
    initial begin
        int cnt;
        cnt = 0;
        burst_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            burst_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) burst_done = 1'b1;
                end
                if (cmd_en && cmd_rdy) begin
                    cnt = 3;
                    log_wr.push_back(32'(cmd_wr));
                    log_addr.push_back(32'(cmd_addr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; init_done = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wfifo_level = 11'd0; rfifo_level = 11'd1023; cmd_rdy = 1'b1;
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Frame 1: latency, then a mid-burst restart after two bursts (partial frame)
        init_done = 1'b1; wfifo_level = 11'd20; wr_frame_start = 1'b1;
        step(); wr_frame_start = 1'b0;
        chk("lat_c1_en", 32'(cmd_en), 0);
        step();
        chk("lat_c2_en", 32'(cmd_en), 0);
        step();
        chk("lat_c3_en", 32'(cmd_en), 1);
        chk("lat_c3_wr", 32'(cmd_wr), 1);
        chk("lat_c3_addr", 32'(cmd_addr), 0);
        chk("lat_c3_len", 32'(cmd_len), 3);
        wait_cmds(2, 50);
        step();
        chk("pend_busy", 32'(busy), 1);
        wr_frame_start = 1'b1;
        step(); wr_frame_start = 1'b0;
        wait_cmds(6, 100);
        repeat (30) step();
        chk("f1_count", 32'(log_addr.size()), 6);
        chk_cmd("f1_", 0, 1, 0);
        chk_cmd("f1_", 1, 1, 4);
        chk_cmd("f1_", 2, 1, 0);
        chk_cmd("f1_", 3, 1, 4);
        chk_cmd("f1_", 4, 1, 8);
        chk_cmd("f1_", 5, 1, 12);
        chk("f1_wr_buf", 32'(wr_buf), 0);

        // Frame 2: full previous frame, buffer toggles
        clear_log();
        wr_frame_start = 1'b1;
        step(); wr_frame_start = 1'b0;
        step();
        chk("f2_wr_buf", 32'(wr_buf), 1);
        wait_cmds(4, 100);
        repeat (30) step();
        chk("f2_count", 32'(log_addr.size()), 4);
        for (int i = 0; i < 4; i++) chk_cmd("f2_", i, 1, 32'(32 + 4 * i));
        rd_frame_start = 1'b1;
        step(); rd_frame_start = 1'b0;
        step();
        chk("rdfs_rd_buf", 32'(rd_buf), 0);
        chk("rdfs_wr_buf", 32'(wr_buf), 1);

        // Backpressure on the second read
        clear_log();
        rfifo_level = 11'd0;
        wait_cmds(1, 50);
        cmd_rdy = 1'b0;
        k = 0;
        while (!cmd_en && k < 30) begin
            step();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk($sformatf("bp%0d_en", i), 32'(cmd_en), 1);
            chk($sformatf("bp%0d_wr", i), 32'(cmd_wr), 0);
            chk($sformatf("bp%0d_addr", i), 32'(cmd_addr), 4);
        end
        cmd_rdy = 1'b1;
        wait_cmds(2, 50);
        rfifo_level = 11'd1023;
        repeat (20) step();
        chk("bp_count", 32'(log_addr.size()), 2);
        chk_cmd("bp_", 0, 0, 0);
        chk_cmd("bp_", 1, 0, 4);

        // init_done drops during a read burst
        rfifo_level = 11'd0;
        wait_cmds(3, 50);
        chk("id_busy", 32'(busy), 1);
        init_done = 1'b0;
        repeat (20) step();
        chk("id_count", 32'(log_addr.size()), 3);
        chk_cmd("id_", 2, 0, 8);
        chk("id_cmd_en", 32'(cmd_en), 0);
        chk("id_busy_end", 32'(busy), 0);
        init_done = 1'b1;
        wait_cmds(4, 50);
        chk_cmd("id_", 3, 0, 12);

        // Reset asserted while that burst is in flight
        chk("rw_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("rw");
        step();

        // Contention from reset: first tie goes to write, then alternate
        clear_log();
        rfifo_level = 11'd0; wfifo_level = 11'd20;
        rst_n = 1'b1; wr_frame_start = 1'b1;
        step(); wr_frame_start = 1'b0;
        wait_cmds(8, 200);
        repeat (30) step();
        chk("ct_count", 32'(log_addr.size()), 8);
        for (int i = 0; i < 8; i++) chk_cmd("ct_", i, 32'((i % 2) == 0), 32'(cont_addr[i]));

        // Simultaneous frame starts: write update first, read takes the other buffer
        rfifo_level = 11'd1023; wfifo_level = 11'd0;
        wr_frame_start = 1'b1; rd_frame_start = 1'b1;
        step(); wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        step();
        chk("sim_wr_buf", 32'(wr_buf), 1);
        chk("sim_rd_buf", 32'(rd_buf), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_frame_arbiter.md
Name: ddr_frame_arbiter

Overview:
- Schedules burst commands to the DDR3 memory controller on behalf of two requesters.
  - Camera write path: a write FIFO filled from cmos_frame_data.
  - HDMI read path: a read FIFO drained by the display.
- Manages ping-pong frame buffers: the write buffer and read buffer are never the same.
- Runs in the DDR user-interface clock domain. Frame-start pulses arrive already synchronised.
- Sits between the ov5640_dri/FIFO pair and the DDR controller. The display read side is driven from the same arbiter.

Parameters:
- BURST_LEN, 128: words per burst command; 1..256.
- FRAME_WORDS, 786432: words per frame (1024x768); must be a multiple of BURST_LEN.
- FRAME_STRIDE, 28'h0100000: word-address distance between buffer 0 and buffer 1.
- RFIFO_DEPTH, 1024: read FIFO capacity in words.
- CNT_W, 11: width of the FIFO level inputs.
- ADDR_W, 28: command address width.

Ports:
- clk, input, 1: DDR UI clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- init_done, input, 1: DDR calibration complete AND cam_init_done.
- wr_frame_start, input, 1: one-cycle pulse, camera vsync rising edge.
- rd_frame_start, input, 1: one-cycle pulse, display vsync rising edge.
- wfifo_level, input, CNT_W: words available in the write FIFO.
- rfifo_level, input, CNT_W: words held in the read FIFO.
- cmd_en, output, 1: command valid.
- cmd_wr, output, 1: 1 = write burst, 0 = read burst.
- cmd_addr, output, ADDR_W: burst start word address.
- cmd_len, output, 8: BURST_LEN-1.
- cmd_rdy, input, 1: controller accepts the command.
- burst_done, input, 1: one-cycle pulse when the data phase of the accepted burst ends.
- wr_buf, output, 1: buffer index currently being written.
- rd_buf, output, 1: buffer index currently being read.
- busy, output, 1: a burst is in flight (from command accept to burst_done).

Behaviour:
- Reset values: cmd_en=0, cmd_wr=0, cmd_addr=0, cmd_len=BURST_LEN-1 (constant), wr_buf=0, rd_buf=1, busy=0.
  - Internal reset values: wr_off=0, rd_off=0, wr_active=0, last_grant=read.
- Write request: wr_active & wfifo_level >= BURST_LEN.
  - wr_active sets on wr_frame_start.
  - wr_active clears when wr_off reaches FRAME_WORDS.
- Read request: rfifo_level <= RFIFO_DEPTH-BURST_LEN & rd_off < FRAME_WORDS.
- FSM states IDLE, ARB, CMD, WAIT:
  - IDLE -> ARB when init_done=1 and any request is true.
  - ARB makes a round-robin grant. If both requests are true, the requester not in last_grant wins; the first tie after reset goes to write. Then -> CMD.
  - CMD holds cmd_en=1 until cmd_rdy=1.
    - cmd_wr and cmd_addr are registered on ARB exit and held stable while cmd_en=1.
    - cmd_addr = buf*FRAME_STRIDE + off.
    - On accept (cmd_en & cmd_rdy): cmd_en drops the next cycle, the granted offset += BURST_LEN, busy=1, last_grant updates, -> WAIT.
  - WAIT -> IDLE on burst_done; busy=0 the same edge.
- Latency:
  - cmd_en asserts 2 cycles after the request condition becomes true in IDLE.
  - With cmd_rdy tied high, back-to-back bursts are spaced by burst_done + 2 cycles.
- wr_frame_start handling:
  - Mid-burst (state CMD or WAIT with cmd_wr=1): latched as pending and applied on the cycle after burst_done.
  - Application when the previous frame completed (wr_off==FRAME_WORDS): wr_buf toggles.
  - Application when the previous frame is incomplete (dropped/partial frame): wr_buf does not toggle, and the partial buffer is overwritten.
  - In both cases: wr_off=0, wr_active=1.
- rd_frame_start: rd_buf <= ~wr_buf, rd_off=0.
  - During a read burst it is pending until burst_done, same as the write side.
- Simultaneous wr_frame_start and rd_frame_start: apply the write update first. rd_buf takes the post-update ~wr_buf.
- Offsets never exceed FRAME_WORDS.
  - No request is raised at the end of a frame.
  - The address never crosses into the other buffer.
- init_done falling mid-operation: the current command and burst complete normally, then IDLE; no new grants are made. Offsets and buffers are retained.
- cmd_rdy is ignored when cmd_en=0. burst_done outside WAIT is ignored.
- Asynchronous reset at any time returns all state to the reset values immediately. An in-flight burst is abandoned.

Test Plan:
- Test parameters: BURST_LEN=4, FRAME_WORDS=16, FRAME_STRIDE=32, cmd_rdy=1, burst_done pulsed 3 cycles after accept.
- Write only: init_done=1, wr_frame_start, wfifo_level=20 -> 4 write commands at cmd_addr 0,4,8,12, cmd_len=3. Then no further requests.
- Second wr_frame_start after a full frame -> wr_buf=1; next writes at 32,36,40,44. rd_frame_start then gives rd_buf=0.
- Contention: both requests true continuously -> grants alternate W,R,W,R; the first grant is write.
- Partial frame: wr_frame_start after 2 bursts -> wr_buf is unchanged and the next write is at cmd_addr 0.
- Backpressure: cmd_rdy low for 5 cycles -> cmd_en, cmd_addr and cmd_wr are stable for 5 cycles. Accept on the 6th; the offset advances exactly once.
- init_done low, or reset asserted in WAIT:
  - init_done low: the burst finishes and no new cmd_en is issued.
  - rst_n low: all outputs reach their reset values within the same cycle.
